multi_cycle_ctrl: RTL and testbench

- Multi-cycle sequencer for the MIPS-subset datapath: register file, ALU, data RAM, PC unit, and an instruction register (IR) loaded once per instruction.
- Replaces the single-cycle op/funct decoder. Each instruction is split into IF/ID/EX/MEM/WB phases, with write enables gated per phase.
- Adds step control through run, and a sticky trap on illegal opcodes or arithmetic overflow.

---
 rtl/multi_cycle_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// multi_cycle_ctrl
//   Multi-cycle sequencer for the MIPS-subset datapath. Each instruction is
//   broken into IF / ID / EX / MEM / WB phases, and the datapath write
//   enables are gated per phase. The block also adds single-step control via
//   run and a sticky trap state for illegal opcodes or arithmetic overflow.
//
// Parameters
//   TRAP_ON_OF   1: overflowing add/sub/addi skips writeback and enters S_TRAP
//                0: the OF flag is ignored
//
// Ports
//   clk        in   system clock, all state changes on the rising edge
//   rst        in   asynchronous active-low reset
//   run        in   permission to fetch the next instruction (checked in S_IF)
//   op_code    in   IR[31:26], valid from S_ID onward
//   funct      in   IR[5:0]
//   ZF, OF     in   ALU zero / overflow flags, sampled in S_EX
//   IR_Write   out  load the instruction register
//   PC_Write   out  load the PC from the source chosen by PC_s
//   PC_s       out  00 PC+4, 01 rs (jr), 10 branch target, 11 jump target
//   ALU_OP     out  ALU operation select
//   imm_s      out  1 sign-extend the immediate, 0 zero-extend it
//   rt_imm_s   out  1 ALU B = immediate, 0 ALU B = rt data
//   w_r_s      out  destination register: 00 rd, 01 rt, 10 r31
//   wr_data_s  out  write data: 00 ALU, 01 memory, 10 return address
//   Write_Reg  out  register-file write enable
//   Mem_Write  out  data-RAM write enable
//   state      out  current FSM state encoding
//   trap       out  high while the sequencer sits in S_TRAP
// ---------------------------------------------------------------------------
module multi_cycle_ctrl #(
  parameter bit TRAP_ON_OF = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [5:0] op_code,
  input  logic [5:0] funct,
  input  logic       ZF,
  input  logic       OF,
  output logic       IR_Write,
  output logic       PC_Write,
  output logic [1:0] PC_s,
  output logic [2:0] ALU_OP,
  output logic       imm_s,
  output logic       rt_imm_s,
  output logic [1:0] w_r_s,
  output logic [1:0] wr_data_s,
  output logic       Write_Reg,
  output logic       Mem_Write,
  output logic [2:0] state,
  output logic       trap
);

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EX   = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100,
    S_TRAP = 3'b111
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] op_q, funct_q;

  // Instruction class flags and ALU controls produced by the decoder
  logic       isRAlu, isIAlu, isLw, isSw, isBeq, isBne, isJ, isJal, isJr;
  logic       canOf, legal;
  logic [2:0] aluOp;
  logic       immS, rtImmS;
  logic [5:0] decOp, decFunct;

  // In S_ID the IR fields are only available live; from EX onward the
  // copies latched at the end of ID drive the decoder.
  assign decOp    = (state_q == S_ID) ? op_code : op_q;
  assign decFunct = (state_q == S_ID) ? funct   : funct_q;

  // Decoder: classify the instruction and pick the ALU operation and the
  // immediate handling that EX and WB will present to the datapath.
  always_comb begin
    isRAlu = 1'b0; isIAlu = 1'b0; isLw  = 1'b0; isSw = 1'b0;
    isBeq  = 1'b0; isBne  = 1'b0; isJ   = 1'b0; isJal = 1'b0;
    isJr   = 1'b0; canOf  = 1'b0;
    aluOp  = 3'b000;
    immS   = 1'b0;
    rtImmS = 1'b0;
    case (decOp)
      6'b000000: begin
        isRAlu = 1'b1;
        case (decFunct)
          6'b100000: begin aluOp = 3'b100; canOf = 1'b1; end
          6'b100010: begin aluOp = 3'b101; canOf = 1'b1; end
          6'b100100: aluOp = 3'b000;
          6'b100101: aluOp = 3'b001;
          6'b100110: aluOp = 3'b010;
          6'b100111: aluOp = 3'b011;
          6'b101011: aluOp = 3'b110;
          6'b000100: aluOp = 3'b111;
          6'b001000: begin isRAlu = 1'b0; isJr = 1'b1; end
          default:   isRAlu = 1'b0;
        endcase
      end
      6'b001000: begin isIAlu = 1'b1; aluOp = 3'b100; immS = 1'b1; rtImmS = 1'b1; canOf = 1'b1; end
      6'b001100: begin isIAlu = 1'b1; aluOp = 3'b000; rtImmS = 1'b1; end
      6'b001101: begin isIAlu = 1'b1; aluOp = 3'b001; rtImmS = 1'b1; end
      6'b001110: begin isIAlu = 1'b1; aluOp = 3'b010; rtImmS = 1'b1; end
      6'b001011: begin isIAlu = 1'b1; aluOp = 3'b110; immS = 1'b1; rtImmS = 1'b1; end
      6'b100011: begin isLw = 1'b1; aluOp = 3'b100; immS = 1'b1; rtImmS = 1'b1; end
      6'b101011: begin isSw = 1'b1; aluOp = 3'b100; immS = 1'b1; rtImmS = 1'b1; end
      6'b000100: begin isBeq = 1'b1; aluOp = 3'b101; end
      6'b000101: begin isBne = 1'b1; aluOp = 3'b101; end
      6'b000010: isJ   = 1'b1;
      6'b000011: isJal = 1'b1;
      default: ;
    endcase
  end

  assign legal = isRAlu | isIAlu | isLw | isSw | isBeq | isBne | isJ | isJal | isJr;

  // State register plus the op/funct copies captured as ID completes.
  // Reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IF;
      op_q    <= 6'd0;
      funct_q <= 6'd0;
    end else begin
      state_q <= state_d;
      if (state_q == S_ID) begin
        op_q    <= op_code;
        funct_q <= funct;
      end
    end
  end

  assign state = state_q;
  assign trap  = (state_q == S_TRAP);

  // Next-state and per-phase outputs. Every enable defaults low and the
  // whole case is skipped while rst is low, so an asynchronous reset drops
  // any partially asserted write in the same instant.
  always_comb begin
    state_d   = state_q;
    IR_Write  = 1'b0;
    PC_Write  = 1'b0;
    PC_s      = 2'b00;
    ALU_OP    = 3'b000;
    imm_s     = 1'b0;
    rt_imm_s  = 1'b0;
    w_r_s     = 2'b00;
    wr_data_s = 2'b00;
    Write_Reg = 1'b0;
    Mem_Write = 1'b0;
    if (rst) begin
      case (state_q)
        S_IF: begin
          if (run) begin
            IR_Write = 1'b1;
            PC_Write = 1'b1;
            state_d  = S_ID;
          end
        end
        S_ID: begin
          if (isJ || isJal) begin
            PC_Write = 1'b1;
            PC_s     = 2'b11;
            if (isJal) begin
              Write_Reg = 1'b1;
              w_r_s     = 2'b10;
              wr_data_s = 2'b10;
            end
            state_d = S_IF;
          end else if (isJr) begin
            PC_Write = 1'b1;
            PC_s     = 2'b01;
            state_d  = S_IF;
          end else if (!legal) begin
            state_d = S_TRAP;
          end else begin
            state_d = S_EX;
          end
        end
        S_EX: begin
          ALU_OP   = aluOp;
          imm_s    = immS;
          rt_imm_s = rtImmS;
          if (isBeq || isBne) begin
            if ((isBeq && ZF) || (isBne && !ZF)) begin
              PC_Write = 1'b1;
              PC_s     = 2'b10;
            end
            state_d = S_IF;
          end else if (isLw || isSw) begin
            state_d = S_MEM;
          end else if (isRAlu || isIAlu) begin
            state_d = (TRAP_ON_OF && canOf && OF) ? S_TRAP : S_WB;
          end else begin
            state_d = S_IF;
          end
        end
        S_MEM: begin
          // Keep the effective-address computation stable across the access
          ALU_OP   = 3'b100;
          imm_s    = 1'b1;
          rt_imm_s = 1'b1;
          if (isSw) begin
            Mem_Write = 1'b1;
            state_d   = S_IF;
          end else begin
            state_d = S_WB;
          end
        end
        S_WB: begin
          ALU_OP    = aluOp;
          imm_s     = immS;
          rt_imm_s  = rtImmS;
          Write_Reg = 1'b1;
          if (isRAlu) begin
            w_r_s     = 2'b00;
            wr_data_s = 2'b00;
          end else if (isLw) begin
            w_r_s     = 2'b01;
            wr_data_s = 2'b01;
          end else begin
            w_r_s     = 2'b01;
            wr_data_s = 2'b00;
          end
          state_d = S_IF;
        end
        S_TRAP: state_d = S_TRAP;
        default: state_d = S_IF;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multi_cycle_ctrl
//   Directed bench for multi_cycle_ctrl. A table of per-cycle records walks
//   the sequencer through each instruction class; hand-written sequences
//   then cover traps and a reset that lands in the middle of a store.
// ---------------------------------------------------------------------------
module tb_multi_cycle_ctrl;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTIU= 6'b001011;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BAD  = 6'b111111;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_JR   = 6'b001000;

  localparam logic [2:0] ST_IF = 3'b000, ST_ID = 3'b001, ST_EX = 3'b010,
                         ST_MEM = 3'b011, ST_WB = 3'b100, ST_TRAP = 3'b111;

  logic       clk, rst, run, ZF, OF;
  logic [5:0] op_code, funct;
  logic       IR_Write, PC_Write, imm_s, rt_imm_s, Write_Reg, Mem_Write, trap;
  logic [1:0] PC_s, w_r_s, wr_data_s;
  logic [2:0] ALU_OP, state;

  int errors = 0;
  int checks = 0;

  // One record per clock: inputs applied in that cycle and the outputs
  // expected while they are applied. chk marks cycles where the ALU
  // controls matter; PC_s and the writeback selects are only compared
  // when their enable is expected high.
  typedef struct {
    logic       run;
    logic [5:0] op;
    logic [5:0] fn;
    logic       zf;
    logic       of;
    logic [2:0] st;
    logic       irw;
    logic       pcw;
    logic [1:0] pcs;
    logic       chk;
    logic [2:0] alu;
    logic       imms;
    logic       rtimm;
    logic       wr;
    logic [1:0] wrs;
    logic [1:0] wds;
    logic       mw;
    logic       trp;
  } vec_t;

  vec_t vecs[$];

  multi_cycle_ctrl #(.TRAP_ON_OF(1'b1)) dut (
    .clk(clk), .rst(rst), .run(run), .op_code(op_code), .funct(funct),
    .ZF(ZF), .OF(OF), .IR_Write(IR_Write), .PC_Write(PC_Write), .PC_s(PC_s),
    .ALU_OP(ALU_OP), .imm_s(imm_s), .rt_imm_s(rt_imm_s), .w_r_s(w_r_s),
    .wr_data_s(wr_data_s), .Write_Reg(Write_Reg), .Mem_Write(Mem_Write),
    .state(state), .trap(trap)
  );

  // Free-running clock, 10 time units per period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input logic r, input logic [5:0] op, input logic [5:0] fn,
                              input logic zf, input logic of, input logic [2:0] st,
                              input logic irw, input logic pcw, input logic [1:0] pcs,
                              input logic chk, input logic [2:0] alu, input logic imms,
                              input logic rtimm, input logic wr, input logic [1:0] wrs,
                              input logic [1:0] wds, input logic mw, input logic trp);
    vec_t v;
    v.run = r; v.op = op; v.fn = fn; v.zf = zf; v.of = of; v.st = st;
    v.irw = irw; v.pcw = pcw; v.pcs = pcs; v.chk = chk; v.alu = alu;
    v.imms = imms; v.rtimm = rtimm; v.wr = wr; v.wrs = wrs; v.wds = wds;
    v.mw = mw; v.trp = trp;
    return v;
  endfunction

  // Common per-phase records for a given instruction
  function automatic vec_t vIf(input logic [5:0] op, input logic [5:0] fn);
    return mk(1, op, fn, 0, 0, ST_IF, 1, 1, 2'b00, 0, 3'b000, 0, 0, 0, 2'b00, 2'b00, 0, 0);
  endfunction

  function automatic vec_t vId(input logic [5:0] op, input logic [5:0] fn);
    return mk(1, op, fn, 0, 0, ST_ID, 0, 0, 2'b00, 0, 3'b000, 0, 0, 0, 2'b00, 2'b00, 0, 0);
  endfunction

  // Drive one cycle of inputs half a period before the next rising edge
  task automatic applyStimulus(input logic r, input logic [5:0] op, input logic [5:0] fn,
                               input logic zf, input logic of);
    @(negedge clk);
    run = r; op_code = op; funct = fn; ZF = zf; OF = of;
    #1;
  endtask

  // Compare the DUT outputs against a record, masking don't-care fields
  task automatic checkOutput(input string nm, input vec_t v);
    logic [18:0] act, exp, mask;
    act  = {state, IR_Write, PC_Write, PC_s, ALU_OP, imm_s, rt_imm_s,
            w_r_s, wr_data_s, Write_Reg, Mem_Write, trap};
    exp  = {v.st, v.irw, v.pcw, v.pcs, v.alu, v.imms, v.rtimm,
            v.wrs, v.wds, v.wr, v.mw, v.trp};
    mask = {3'b111, 1'b1, 1'b1, {2{v.pcw}}, {3{v.chk}}, v.chk & v.rtimm, v.chk,
            {2{v.wr}}, {2{v.wr}}, 1'b1, 1'b1, 1'b1};
    checks++;
    if (((act ^ exp) & mask) != 19'd0) begin
      errors++;
      $display("[TB] FAIL %s: got state=%b irw=%b pcw=%b pcs=%b alu=%b imm=%b rtimm=%b wrs=%b wds=%b wr=%b mw=%b trap=%b, expected %05h under mask %05h (got %05h)",
               nm, state, IR_Write, PC_Write, PC_s, ALU_OP, imm_s, rt_imm_s,
               w_r_s, wr_data_s, Write_Reg, Mem_Write, trap, exp & mask, mask, act & mask);
    end
  endtask

  // Reset with run high to confirm the enables stay low, then release with
  // run low so the sequencer is parked in IF for the first vector.
  task automatic resetDut();
    @(negedge clk);
    rst = 1'b0; run = 1'b1; op_code = OP_R; funct = FN_ADD; ZF = 1'b0; OF = 1'b0;
    #1;
    checkOutput("reset", mk(1, OP_R, FN_ADD, 0, 0, ST_IF, 0, 0, 2'b00, 0, 3'b000, 0, 0, 0, 2'b00, 2'b00, 0, 0));
    run = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic runVec(input string nm, input vec_t v);
    applyStimulus(v.run, v.op, v.fn, v.zf, v.of);
    checkOutput(nm, v);
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; op_code = 6'd0; funct = 6'd0; ZF = 1'b0; OF = 1'b0;

    // add $3,$1,$2 : IF ID EX WB
    vecs.push_back(vIf(OP_R, FN_ADD));
    vecs.push_back(vId(OP_R, FN_ADD));
    vecs.push_back(mk(1, OP_R, FN_ADD, 0, 0, ST_EX, 0, 0, 2'b00, 1, 3'b100, 0, 0, 0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk(1, OP_R, FN_ADD, 0, 0, ST_WB, 0, 0, 2'b00, 1, 3'b100, 0, 0, 1, 2'b00, 2'b00, 0, 0));
    // lw $5,4($0) : IF ID EX MEM WB
    vecs.push_back(vIf(OP_LW, 6'b000100));
    vecs.push_back(vId(OP_LW, 6'b000100));
    vecs.push_back(mk(1, OP_LW, 6'b000100, 0, 0, ST_EX, 0, 0, 2'b00, 1, 3'b100, 1, 1, 0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk(1, OP_LW, 6'b000100, 0, 0, ST_MEM, 0, 0, 2'b00, 1, 3'b100, 1, 1, 0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk(1, OP_LW, 6'b000100, 0, 0, ST_WB, 0, 0, 2'b00, 1, 3'b100, 1, 1, 1, 2'b01, 2'b01, 0, 0));
    // sw $5,8($0) : IF ID EX MEM
    vecs.push_back(vIf(OP_SW, 6'b001000));
    vecs.push_back(vId(OP_SW, 6'b001000));
    vecs.push_back(mk(1, OP_SW, 6'b001000, 0, 0, ST_EX, 0, 0, 2'b00, 1, 3'b100, 1, 1, 0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk(1, OP_SW, 6'b001000, 0, 0, ST_MEM, 0, 0, 2'b00, 1, 3'b100, 1, 1, 0, 2'b00, 2'b00, 1, 0));
    // beq taken, beq not taken, bne taken, bne not taken
    vecs.push_back(vIf(OP_BEQ, 6'd3));
    vecs.push_back(vId(OP_BEQ, 6'd3));
    vecs.push_back(mk(1, OP_BEQ, 6'd3, 1, 0, ST_EX, 0, 1, 2'b10, 1, 3'b101, 0, 0, 0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(vIf(OP_BEQ, 6'd3));
    vecs.push_back(vId(OP_BEQ, 6'd3));
    vecs.push_back(mk(1, OP_BEQ, 6'd3, 0, 0, ST_EX, 0, 0, 2'b00, 1, 3'b101, 0, 0, 0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(vIf(OP_BNE, 6'd3));
    vecs.push_back(vId(OP_BNE, 6'd3));
    vecs.push_back(mk(1, OP_BNE, 6'd3, 0, 0, ST_EX, 0, 1, 2'b10, 1, 3'b101, 0, 0, 0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(vIf(OP_BNE, 6'd3));
    vecs.push_back(vId(OP_BNE, 6'd3));
    vecs.push_back(mk(1, OP_BNE, 6'd3, 1, 0, ST_EX, 0, 0, 2'b00, 1, 3'b101, 0, 0, 0, 2'b00, 2'b00, 0, 0));
    // run low parks the sequencer in IF with no fetch
    vecs.push_back(mk(0, OP_R, FN_ADD, 0, 0, ST_IF, 0, 0, 2'b00, 0, 3'b000, 0, 0, 0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk(0, OP_R, FN_ADD, 0, 0, ST_IF, 0, 0, 2'b00, 0, 3'b000, 0, 0, 0, 2'b00, 2'b00, 0, 0));
    // ori (zero-extended immediate, writes rt)
    vecs.push_back(vIf(OP_ORI, 6'd7));
    vecs.push_back(vId(OP_ORI, 6'd7));
    vecs.push_back(mk(1, OP_ORI, 6'd7, 0, 0, ST_EX, 0, 0, 2'b00, 1, 3'b001, 0, 1, 0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk(1, OP_ORI, 6'd7, 0, 0, ST_WB, 0, 0, 2'b00, 1, 3'b001, 0, 1, 1, 2'b01, 2'b00, 0, 0));
    // sltiu (sign-extended immediate)
    vecs.push_back(vIf(OP_SLTIU, 6'd1));
    vecs.push_back(vId(OP_SLTIU, 6'd1));
    vecs.push_back(mk(1, OP_SLTIU, 6'd1, 0, 0, ST_EX, 0, 0, 2'b00, 1, 3'b110, 1, 1, 0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk(1, OP_SLTIU, 6'd1, 0, 0, ST_WB, 0, 0, 2'b00, 1, 3'b110, 1, 1, 1, 2'b01, 2'b00, 0, 0));
    // sub without overflow completes normally
    vecs.push_back(vIf(OP_R, FN_SUB));
    vecs.push_back(vId(OP_R, FN_SUB));
    vecs.push_back(mk(1, OP_R, FN_SUB, 0, 0, ST_EX, 0, 0, 2'b00, 1, 3'b101, 0, 0, 0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk(1, OP_R, FN_SUB, 0, 0, ST_WB, 0, 0, 2'b00, 1, 3'b101, 0, 0, 1, 2'b00, 2'b00, 0, 0));
    // jal 0x0C000010, j, jr : two cycles each
    vecs.push_back(vIf(OP_JAL, 6'b010000));
    vecs.push_back(mk(1, OP_JAL, 6'b010000, 0, 0, ST_ID, 0, 1, 2'b11, 0, 3'b000, 0, 0, 1, 2'b10, 2'b10, 0, 0));
    vecs.push_back(vIf(OP_J, 6'd0));
    vecs.push_back(mk(1, OP_J, 6'd0, 0, 0, ST_ID, 0, 1, 2'b11, 0, 3'b000, 0, 0, 0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(vIf(OP_R, FN_JR));
    vecs.push_back(mk(1, OP_R, FN_JR, 0, 0, ST_ID, 0, 1, 2'b01, 0, 3'b000, 0, 0, 0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk(0, OP_R, FN_ADD, 0, 0, ST_IF, 0, 0, 2'b00, 0, 3'b000, 0, 0, 0, 2'b00, 2'b00, 0, 0));

    resetDut();
    for (int i = 0; i < vecs.size(); i++) begin
      runVec($sformatf("vec%0d", i), vecs[i]);
    end

    // Illegal opcode traps from ID and stays trapped with run held high
    resetDut();
    runVec("bad_if", vIf(OP_BAD, 6'd0));
    runVec("bad_id", vId(OP_BAD, 6'd0));
    for (int i = 0; i < 10; i++) begin
      runVec($sformatf("bad_trap%0d", i),
             mk(1, OP_R, FN_ADD, 0, 0, ST_TRAP, 0, 0, 2'b00, 0, 3'b000, 0, 0, 0, 2'b00, 2'b00, 0, 1));
    end

    // add with overflow: no writeback, trap is sticky
    resetDut();
    runVec("of_if", vIf(OP_R, FN_ADD));
    runVec("of_id", vId(OP_R, FN_ADD));
    runVec("of_ex", mk(1, OP_R, FN_ADD, 0, 1, ST_EX, 0, 0, 2'b00, 1, 3'b100, 0, 0, 0, 2'b00, 2'b00, 0, 0));
    for (int i = 0; i < 10; i++) begin
      runVec($sformatf("of_trap%0d", i),
             mk(1, OP_R, FN_ADD, 0, 0, ST_TRAP, 0, 0, 2'b00, 0, 3'b000, 0, 0, 0, 2'b00, 2'b00, 0, 1));
    end

    // Reset asserted during the MEM cycle of a store drops Mem_Write at once
    resetDut();
    runVec("swr_if", vIf(OP_SW, 6'd8));
    runVec("swr_id", vId(OP_SW, 6'd8));
    runVec("swr_ex", mk(1, OP_SW, 6'd8, 0, 0, ST_EX, 0, 0, 2'b00, 1, 3'b100, 1, 1, 0, 2'b00, 2'b00, 0, 0));
    runVec("swr_mem", mk(1, OP_SW, 6'd8, 0, 0, ST_MEM, 0, 0, 2'b00, 1, 3'b100, 1, 1, 0, 2'b00, 2'b00, 1, 0));
    rst = 1'b0;
    #1;
    checkOutput("swr_async_rst", mk(1, OP_SW, 6'd8, 0, 0, ST_IF, 0, 0, 2'b00, 0, 3'b000, 0, 0, 0, 2'b00, 2'b00, 0, 0));
    @(negedge clk);
    run = 1'b0;
    rst = 1'b1;
    runVec("swr_after", vIf(OP_R, FN_ADD));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
